// File: rtl/asg_pkg.sv
// asg_pkg: shared FSM/mode types and signed range helpers for the ASG memory writer
package asg_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  typedef enum logic {ASG_ARITH, ASG_GEOM} mode_t;
  function automatic logic signed [63:0] smax(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] smin(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/asg_mem_writer_param_term_calc.sv
// asg_term_calc: combinational next term (add/mul), saturating when ASG_SATURATE_EN is defined
module asg_term_calc import asg_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic                     mode,
  input  logic signed [DATA_W-1:0] term,
  input  logic signed [DATA_W-1:0] d,
  output logic signed [DATA_W-1:0] next_term
`ifdef ASG_SATURATE_EN
  ,
  output logic                     ovf
`endif
);
`ifdef ASG_SATURATE_EN
  localparam int WW = 2 * DATA_W;
  logic signed [WW-1:0] prod, sum, wide, mx, mn;
  assign prod = term * d;
  assign sum = term + d;
  assign mx = WW'(smax(DATA_W));
  assign mn = WW'(smin(DATA_W));
  assign wide = mode ? prod : sum;
  assign ovf = wide > mx || wide < mn;
  assign next_term = wide > mx ? mx[DATA_W-1:0] : wide < mn ? mn[DATA_W-1:0] : wide[DATA_W-1:0];
`else
  assign next_term = mode ? term * d : term + d;
`endif
endmodule

// File: rtl/asg_mem_writer_param.sv
// asg_mem_writer_param: arith/geom sequence writer with ready/valid memory port; ASG_SATURATE_EN enables clamping
module asg_mem_writer_param import asg_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] d,
  input  logic [CNT_W-1:0]  n,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(1) << ADDR_W;
  state_t state, state_nxt;
  mode_t cfg_mode;
  logic signed [DATA_W-1:0] cfg_d, term, next_term;
  logic [CNT_W-1:0] cfg_n, count;
  logic n_ok, acc, last;
`ifdef ASG_SATURATE_EN
  logic sat, ovf;
`endif
  assign n_ok = n != '0 && n <= DEPTH;
  assign acc = state == WRITE && mem_ready && !abort;
  assign last = count + CNT_W'(1) == cfg_n;
  assign mem_we = state == WRITE;
  assign busy = state == WRITE;
  assign done = state == DONE;
  assign mem_wdata = term;
  asg_term_calc #(.DATA_W(DATA_W)) u_calc (
    .mode(cfg_mode == ASG_GEOM),
    .term(term),
    .d(cfg_d),
    .next_term(next_term)
`ifdef ASG_SATURATE_EN
    ,
    .ovf(ovf)
`endif
  );
  always_comb begin
    state_nxt = state;
    if (state == IDLE && start) state_nxt = n_ok ? WRITE : DONE;
    else if (state == WRITE) state_nxt = abort ? IDLE : (acc && last) ? DONE : WRITE;
    else if (state == DONE && (abort || !start)) state_nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cfg_mode <= ASG_ARITH;
      cfg_d <= '0;
      cfg_n <= '0;
      term <= '0;
      count <= '0;
      mem_addr <= '0;
      err <= 1'b0;
`ifdef ASG_SATURATE_EN
      sat <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      err <= state_nxt == DONE && (state == DONE ? err : state == IDLE);
      if (state == IDLE && start && n_ok) begin
        cfg_mode <= mode_t'(mode);
        cfg_d <= d;
        cfg_n <= n;
        term <= a1;
        count <= '0;
        mem_addr <= base_addr;
`ifdef ASG_SATURATE_EN
        sat <= 1'b0;
`endif
      end else if (acc) begin
        count <= count + CNT_W'(1);
        if (!last) begin
          mem_addr <= mem_addr + ADDR_W'(1);
`ifdef ASG_SATURATE_EN
          term <= sat ? term : next_term;
          sat <= sat | ovf;
`else
          term <= next_term;
`endif
        end
      end
    end
  end
endmodule
